fast_corner_collect: RTL

Downstream stage of the 7x7 FAST detector. Consumes the per-window corner flag and 8-bit score stream, tracks window-centre pixel coordinates and packs each accepted corner into an `{y, x, score}` record. Records are buffered in a small FIFO and drained over a valid/ready port. Per-frame corner and drop counts are latched at each start-of-frame for the frame-statistics registers.

---
 rtl/fast_corner_collect.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fast_corner_collect.sv
// fast_corner_collect: FAST corner record collector.
// Tracks window-centre coordinates, packs accepted corners as {y, x, score},
// buffers them in a FIFO and latches per-frame accept/drop counts at sof.
// Ports: c/r clock and sync active-high reset; sof start-of-frame;
//   sv/qv/q score strobe, corner flag, score; ov/ordy/od record output
//   handshake; frame_done/frame_corners/frame_drops frame statistics.
// Optional: define FAST_CORNER_NMS_EN for 1-D horizontal non-max suppression.
module fast_corner_collect #(
    parameter int XW          = 11,
    parameter int YW          = 10,
    parameter int WIDTH       = 1280,
    parameter int X_OFS       = 3,
    parameter int Y_OFS       = 3,
    parameter int DEPTH       = 16,
    parameter int MAX_CORNERS = 1023
) (
    input  logic             c,
    input  logic             r,
    input  logic             sof,
    input  logic             sv,
    input  logic             qv,
    input  logic [7:0]       q,
    output logic             ov,
    input  logic             ordy,
    output logic [YW+XW+7:0] od,
    output logic             frame_done,
    output logic [15:0]      frame_corners,
    output logic [15:0]      frame_drops
);

    localparam int RW = YW + XW + 8;
    localparam int AW = $clog2(DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v,
                                            input logic inc);
        return (inc && v != 16'hffff) ? v + 16'd1 : v;
    endfunction

    logic [XW-1:0] col, bcol, ncol, cx;
    logic [YW-1:0] row, brow, nrow, cy;
    logic          last;
    logic [RW-1:0] cur_rec, rec;
    logic          req, push, drop, pop, full, cap_ok, stale;
    logic [15:0]   acc, drp, bacc, bdrp;
    logic [AW:0]   wp, rp, cnt;
    logic [RW-1:0] mem [DEPTH];

    // sof zeroes the frame state ahead of a coincident sv, so the
    // b* values are what the current strobe actually sees.
    always_comb begin
        bcol    = sof ? '0 : col;
        brow    = sof ? '0 : row;
        bacc    = sof ? '0 : acc;
        bdrp    = sof ? '0 : drp;
        last    = (bcol == XW'(WIDTH - 1));
        ncol    = last ? '0 : bcol + 1'b1;
        nrow    = last ? brow + 1'b1 : brow;
        cx      = bcol + XW'(X_OFS);
        cy      = brow + YW'(Y_OFS);
        cur_rec = {cy, cx, q};
    end

`ifdef FAST_CORNER_NMS_EN
    logic          held_v;
    logic [7:0]    held_s, held_l, prev_s, cur_s, left;
    logic [RW-1:0] held_rec;
    logic          bheld, rel_h, rel_e;

    // Row start has no left neighbour; non-corners score 0.
    always_comb begin
        bheld = held_v & ~sof;
        cur_s = qv ? q : 8'd0;
        left  = (bcol == '0) ? 8'd0 : prev_s;
        rel_h = sv & bheld & (held_s >= held_l) & (held_s > cur_s);
        rel_e = sv & qv & last & (q >= left);
        req   = rel_h | rel_e;
        rec   = rel_h ? held_rec : cur_rec;
        stale = held_v;
    end

    // Every sv consumes the held candidate, released or suppressed.
    always_ff @(posedge c) begin
        if (r) begin
            held_v   <= 1'b0;
            held_s   <= '0;
            held_l   <= '0;
            held_rec <= '0;
            prev_s   <= '0;
        end else if (sv) begin
            held_v   <= qv & ~last;
            held_s   <= q;
            held_l   <= left;
            held_rec <= cur_rec;
            prev_s   <= cur_s;
        end else if (sof) begin
            held_v   <= 1'b0;
        end
    end
`else
    always_comb begin
        req   = sv & qv;
        rec   = cur_rec;
        stale = 1'b0;
    end
`endif

    // Full uses pre-pop occupancy: a same-cycle pop does not make room.
    always_comb begin
        cnt    = wp - rp;
        full   = (cnt == (AW+1)'(DEPTH));
        cap_ok = (32'(bacc) < 32'(MAX_CORNERS));
        push   = req & ~full & cap_ok;
        drop   = req & ~push;
        ov     = (wp != rp);
        pop    = ov & ordy;
        od     = ov ? mem[rp[AW-1:0]] : '0;
    end

    always_ff @(posedge c) begin
        if (push)
            mem[wp[AW-1:0]] <= rec;
    end

    always_ff @(posedge c) begin
        if (r) begin
            col           <= '0;
            row           <= '0;
            acc           <= '0;
            drp           <= '0;
            wp            <= '0;
            rp            <= '0;
            frame_done    <= 1'b0;
            frame_corners <= '0;
            frame_drops   <= '0;
        end else begin
            frame_done <= sof;
            if (sof) begin
                frame_corners <= acc;
                frame_drops   <= sat_inc(drp, stale);
            end
            if (sv) begin
                col <= ncol;
                row <= nrow;
            end else if (sof) begin
                col <= '0;
                row <= '0;
            end
            acc <= sat_inc(bacc, push);
            drp <= sat_inc(bdrp, drop);
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end
    end

endmodule
